pc_ctrl: RTL

Next-PC sequencer and fetch controller for the PC register of the 5-stage pipeline.
- Selects the next PC from sequential, jump (ID) and branch (EX) sources.
- Generates the PC hold (hazardpc) and IF/ID flush controls.
- Detects the program-end address and parks the core in a halt state.
- Sits between the hazard unit and branch/jump resolution logic on one side, and the PC register on the other.

---
 rtl/pc_ctrl_if.sv | 46 ++++
 rtl/pc_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_ctrl_if.sv
// Fetch-control bundle between hazard/redirect logic and the PC sequencer.
// Master drives requests and current PC; slave (pc_ctrl) returns next-PC controls.
interface pc_ctrl_if;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_next_o;
  logic        hazardpc_o;
  logic        flush_o;
  logic        halt_o;
  logic        misalign_o;
  logic [31:0] cycle_cnt_o;

  modport master (
    output pc_i,
    output stall_i,
    output jump_i,
    output jump_target_i,
    output branch_i,
    output branch_target_i,
    input  pc_next_o,
    input  hazardpc_o,
    input  flush_o,
    input  halt_o,
    input  misalign_o,
    input  cycle_cnt_o
  );

  modport slave (
    input  pc_i,
    input  stall_i,
    input  jump_i,
    input  jump_target_i,
    input  branch_i,
    input  branch_target_i,
    output pc_next_o,
    output hazardpc_o,
    output flush_o,
    output halt_o,
    output misalign_o,
    output cycle_cnt_o
  );
endinterface

// File: rtl/pc_ctrl.sv
// Next-PC sequencer: branch/jump/stall select, flush window, halt park.
// Optional misaligned-redirect trap enabled by PC_CTRL_MISALIGN_TRAP_EN.
module pc_ctrl #(
  parameter logic [31:0] RESET_ADDR   = 32'd0,
  parameter logic [31:0] HALT_ADDR    = 32'd248,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic   clk_i,
  input logic   start_i,
  pc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [1:0]  fcnt_q;
  logic [1:0]  fcnt_d;
  logic [31:0] cnt_q;

  logic [31:0] tgt;
  logic [31:0] tgt_aligned;
  logic        redirect;
  logic        bad_tgt;
  logic [31:0] pc_next;
  logic        hazardpc;
  logic        flush;

  always_comb begin
    tgt         = bus.branch_i ? bus.branch_target_i
                               : bus.jump_target_i;
    tgt_aligned = tgt & 32'hFFFF_FFFC;
    redirect    = (state_q != HALT)
                & (bus.branch_i | bus.jump_i);
  end

`ifdef PC_CTRL_MISALIGN_TRAP_EN
  logic mis_q;

  assign bad_tgt = redirect & (tgt[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      mis_q <= 1'b0;
    end else if (bad_tgt) begin
      mis_q <= 1'b1;
    end
  end

  assign bus.misalign_o = mis_q;
`else
  assign bad_tgt        = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    pc_next  = bus.pc_i + 32'd4;
    hazardpc = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      HALT: begin
        pc_next  = bus.pc_i;
        hazardpc = 1'b1;
      end
      RUN, FLUSH: begin
        flush = (state_q == FLUSH);
        if (redirect) begin
          flush   = 1'b1;
          pc_next = bad_tgt ? HALT_ADDR : tgt_aligned;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = 2'(FLUSH_CYCLES - 1);
          end else begin
            state_d = RUN;
            fcnt_d  = 2'd0;
          end
        end else begin
          if (bus.stall_i) begin
            pc_next  = bus.pc_i;
            hazardpc = 1'b1;
          end
          // halt check outranks closing the flush window
          if (bus.pc_i == HALT_ADDR) begin
            state_d = HALT;
            fcnt_d  = 2'd0;
          end else if (state_q == FLUSH) begin
            if (fcnt_q <= 2'd1) begin
              state_d = RUN;
              fcnt_d  = 2'd0;
            end else begin
              fcnt_d = fcnt_q - 2'd1;
            end
          end
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      cnt_q <= 32'd0;
    end else if (state_q != HALT) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // reset must win combinationally on the PC-register inputs
  assign bus.pc_next_o   = start_i ? pc_next : RESET_ADDR;
  assign bus.hazardpc_o  = start_i & hazardpc;
  assign bus.flush_o     = start_i & flush;
  assign bus.halt_o      = (state_q == HALT);
  assign bus.cycle_cnt_o = cnt_q;

endmodule
